// File: rtl/video_timing_gen.sv
// Raster timing generator: waits for a qualified PLL lock, then drives
// hs/vs/de and pixel coordinates from free-running line/frame counters.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 13,
  parameter int unsigned V_SYNC    = 3,
  parameter int unsigned V_BP      = 32,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          lock_i,
  output logic                          hs_o,
  output logic                          vs_o,
  output logic                          de_o,
  output logic [$clog2(H_ACTIVE)-1:0]   x_o,
  output logic [$clog2(V_ACTIVE)-1:0]   y_o,
  output logic                          sof_o,
  output logic                          run_o
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW           = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW           = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned LW           = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;
  localparam int unsigned XW           = $clog2(H_ACTIVE);
  localparam int unsigned YW           = $clog2(V_ACTIVE);
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;

  logic            hs_c, vs_c, de_c, sof_c, run_c;
  logic [XW-1:0]   x_c;
  logic [YW-1:0]   y_c;

  // State and counter register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
    end
  end

  // Next state: lock qualification, then raster counting until lock drops
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (lock_i) begin
          if (lock_cnt_q >= LW'(LOCK_WAIT - 1)) begin
            state_d    = RUN;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LW'(1);
          end
        end else begin
          lock_cnt_d = '0;
        end
      end
      RUN: begin
        if (!lock_i) begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
          h_cnt_d    = '0;
          v_cnt_d    = '0;
        end else if (h_cnt_q == HW'(H_TOTAL - 1)) begin
          h_cnt_d = '0;
          if (v_cnt_q == VW'(V_TOTAL - 1)) begin
            v_cnt_d = '0;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Output decode of the current counter position; idle on lock loss so the
  // output register goes idle on the same edge the FSM leaves RUN
  always_comb begin
    hs_c  = ~SYNC_POL;
    vs_c  = ~SYNC_POL;
    de_c  = 1'b0;
    x_c   = '0;
    y_c   = '0;
    sof_c = 1'b0;
    run_c = 1'b0;
    if (state_q == RUN && lock_i) begin
      run_c = 1'b1;
      if (32'(h_cnt_q) >= H_SYNC_START && 32'(h_cnt_q) < H_SYNC_END) begin
        hs_c = SYNC_POL;
      end
      if (32'(v_cnt_q) >= V_SYNC_START && 32'(v_cnt_q) < V_SYNC_END) begin
        vs_c = SYNC_POL;
      end
      if (32'(h_cnt_q) < H_ACTIVE && 32'(v_cnt_q) < V_ACTIVE) begin
        de_c = 1'b1;
        x_c  = XW'(h_cnt_q);
        y_c  = YW'(v_cnt_q);
      end
      sof_c = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // Output register: one clock behind the counters, all outputs aligned
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hs_o  <= ~SYNC_POL;
      vs_o  <= ~SYNC_POL;
      de_o  <= 1'b0;
      x_o   <= '0;
      y_o   <= '0;
      sof_o <= 1'b0;
      run_o <= 1'b0;
    end else begin
      hs_o  <= hs_c;
      vs_o  <= vs_c;
      de_o  <= de_c;
      x_o   <= x_c;
      y_o   <= y_c;
      sof_o <= sof_c;
      run_o <= run_c;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed + randomized bench for video_timing_gen on a tiny 8x6 raster,
// with a per-cycle expected-output scoreboard and directed timing checks.
module tb_video_timing_gen;

  localparam int unsigned H_ACTIVE  = 4;
  localparam int unsigned H_FP      = 1;
  localparam int unsigned H_SYNC    = 2;
  localparam int unsigned H_BP      = 1;
  localparam int unsigned V_ACTIVE  = 3;
  localparam int unsigned V_FP      = 1;
  localparam int unsigned V_SYNC    = 1;
  localparam int unsigned V_BP      = 1;
  localparam int unsigned LOCK_WAIT = 4;

  typedef logic [8:0] vec_t;
  localparam vec_t IDLE = 9'b1_1_0_00_00_0_0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic       hs_o, vs_o, de_o, sof_o, run_o;
  logic [1:0] x_o, y_o;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL (1'b0), .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .lock_i  (lock),
    .hs_o    (hs_o),
    .vs_o    (vs_o),
    .de_o    (de_o),
    .x_o     (x_o),
    .y_o     (y_o),
    .sof_o   (sof_o),
    .run_o   (run_o)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  vec_t sb_q[$];

  // Reference raster: line = 4 active, 1 fp, 2 sync, 1 bp; frame = 3/1/1/1 lines
  bit m_run  = 1'b0;
  int m_lock = 0;
  int m_h    = 0;
  int m_v    = 0;

  function automatic vec_t model_out(input bit rst, input bit lk);
    bit         hs, vs, de, sof;
    logic [1:0] x, y;
    if (!rst || !m_run || !lk) return IDLE;
    de  = (m_h < 4) && (m_v < 3);
    hs  = !(m_h == 5 || m_h == 6);
    vs  = (m_v != 4);
    x   = de ? 2'(m_h) : 2'd0;
    y   = de ? 2'(m_v) : 2'd0;
    sof = (m_h == 0) && (m_v == 0);
    return {hs, vs, de, x, y, sof, 1'b1};
  endfunction

  task automatic model_adv(input bit rst, input bit lk);
    if (!rst) begin
      m_run = 1'b0; m_lock = 0; m_h = 0; m_v = 0;
    end else if (!m_run) begin
      if (!lk) m_lock = 0;
      else if (m_lock == LOCK_WAIT - 1) begin m_run = 1'b1; m_lock = 0; m_h = 0; m_v = 0; end
      else m_lock++;
    end else if (!lk) begin
      m_run = 1'b0; m_lock = 0; m_h = 0; m_v = 0;
    end else begin
      m_h = (m_h + 1) % 8;
      if (m_h == 0) m_v = (m_v + 1) % 6;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected output, compare after the edge
  task automatic step(input bit rst, input bit lk);
    vec_t obs, exp;
    rst_n = rst;
    lock  = lk;
    sb_q.push_back(model_out(rst, lk));
    model_adv(rst, lk);
    @(posedge clk);
    #1;
    cyc++;
    obs = {hs_o, vs_o, de_o, x_o, y_o, sof_o, run_o};
    exp = sb_q.pop_front();
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL sb cyc=%0d observed=%b expected=%b", cyc, obs, exp);
    end
  endtask

  function automatic vec_t out_vec();
    return {hs_o, vs_o, de_o, x_o, y_o, sof_o, run_o};
  endfunction

  initial begin
    logic [4:0] sofh;
    logic [7:0] deh, hsh, xs;
    logic [8:0] runh;
    logic [8:0] pat;
    int         n, vsl, vs_first, dec, y2;

    // Reset state
    repeat (3) step(1'b0, 1'b0);
    chk("reset_idle", 32'(out_vec()), 32'(IDLE));

    // Lock qualification: first sof five cycles after the first lock sample
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      sofh[i] = sof_o;
    end
    chk("qual_sof_hist", 32'(sofh), 32'h10);
    chk("qual_pixel", 32'({de_o, x_o, y_o}), 32'h10);

    // Line timing over one 8-cycle line
    deh = '0; hsh = '0; xs = '0;
    deh[7] = de_o; hsh[7] = hs_o; xs[7:6] = x_o;
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b1);
      deh[7-i] = de_o;
      hsh[7-i] = hs_o;
      if (i < 4) xs[7-2*i -: 2] = x_o;
    end
    chk("line_de", 32'(deh), 32'hF0);
    chk("line_hs", 32'(hsh), 32'hF9);
    chk("line_x", 32'(xs), 32'h1B);

    // Frame timing: walk to the next sof
    n = 7; vsl = 0; vs_first = -1; dec = 4; y2 = 0;
    while (n < 200) begin
      step(1'b1, 1'b1);
      n++;
      if (sof_o) break;
      if (!vs_o) begin vsl++; if (vs_first < 0) vs_first = n; end
      if (de_o) dec++;
      if (de_o && y_o == 2'd2) y2++;
    end
    chk("frame_period", 32'(n), 32'd48);
    chk("frame_vs_len", 32'(vsl), 32'd8);
    chk("frame_vs_start", 32'(vs_first), 32'd32);
    chk("frame_de_count", 32'(dec), 32'd12);
    chk("frame_row2", 32'(y2), 32'd4);

    // Single-cycle lock glitch mid-line
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("glitch_idle", 32'(out_vec()), 32'(IDLE));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      sofh[i] = sof_o;
    end
    chk("glitch_sof_hist", 32'(sofh), 32'h10);

    // Broken qualification run 1,1,1,0 then 1,1,1,1
    step(1'b1, 1'b0);
    pat = 9'b1_1111_0111;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, pat[i]);
      runh[i] = run_o;
    end
    chk("requal_run_hist", 32'(runh), 32'h100);
    chk("requal_sof", 32'(sof_o), 32'd1);

    // Reset pulse during active video
    repeat (9) step(1'b1, 1'b1);
    chk("mid_active", 32'(de_o), 32'd1);
    step(1'b0, 1'b1);
    chk("reset_mid_idle", 32'(out_vec()), 32'(IDLE));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      sofh[i] = sof_o;
    end
    chk("reset_sof_hist", 32'(sofh), 32'h10);

    // Random lock drops and resets against the reference
    repeat (400) step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 24) != 0));
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, horizontal sync width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 32, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)
- LOCK_WAIT, 1024, consecutive lock_i-high cycles required before timing starts
REQ-002 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, pixel clock (PLL output)
- rst_n_i, in, 1, reset
- lock_i, in, 1, PLL lock indicator, synchronous to clk_i
- hs_o, out, 1, horizontal sync
- vs_o, out, 1, vertical sync
- de_o, out, 1, data enable, high on visible pixels
- x_o, out, clog2(H_ACTIVE), visible column, valid when de_o=1
- y_o, out, clog2(V_ACTIVE), visible row, valid when de_o=1
- sof_o, out, 1, one-cycle pulse on pixel (0,0)
- run_o, out, 1, high while timing is running
REQ-003 One clock, clk_i; reset rst_n_i is synchronous and active-low.

Function
REQ-004 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; h_cnt and v_cnt SHALL be sized to hold H_TOTAL-1 and V_TOTAL-1.
REQ-005 FSM states SHALL be exactly WAIT_LOCK and RUN; reset enters WAIT_LOCK.
REQ-006 In WAIT_LOCK, lock_cnt SHALL increment on every lock_i=1 cycle and clear on every lock_i=0 cycle.
REQ-007 The FSM SHALL go to RUN on the cycle after the LOCK_WAIT-th consecutive lock_i=1 sample; h_cnt and v_cnt SHALL be 0 on entry.
REQ-008 In RUN, lock_i=0 for any single cycle SHALL force WAIT_LOCK on the next edge, clear lock_cnt, h_cnt and v_cnt, and drive outputs to idle on that edge.
REQ-009 In RUN, h_cnt SHALL increment each cycle and wrap from H_TOTAL-1 to 0.
REQ-010 v_cnt SHALL increment only on the h_cnt wrap cycle; it SHALL wrap from V_TOTAL-1 to 0 on the cycle where both counters wrap.
REQ-011 Line order SHALL be active, front porch, sync, back porch; the same order SHALL apply to the frame.
REQ-012 hs_o SHALL equal SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL; vs_o SHALL follow the same rule on v_cnt, changing only at h_cnt=0 boundaries.
REQ-013 de_o SHALL be 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-014 When de_o=1, x_o SHALL equal h_cnt and y_o SHALL equal v_cnt; when de_o=0, both SHALL hold 0.
REQ-015 sof_o SHALL be 1 iff h_cnt=0 and v_cnt=0 in RUN.
REQ-016 All outputs SHALL be registered with exactly one clock of latency from the counter state, and SHALL be mutually aligned so that all outputs describe the same counter position.
REQ-017 run_o SHALL be 1 on exactly the output cycles that correspond to RUN counter positions.
REQ-018 In idle (WAIT_LOCK), hs_o and vs_o SHALL be ~SYNC_POL, and de_o, sof_o, run_o, x_o and y_o SHALL be 0.

Reset
REQ-019 On a clk_i edge with rst_n_i=0, all state SHALL be cleared and outputs driven to idle per REQ-018 on that edge, regardless of state.
REQ-020 Reset asserted mid-frame SHALL require a fresh LOCK_WAIT qualification before RUN.

Verification
Scenarios REQ-021 to REQ-025 use H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=0, LOCK_WAIT=4.
REQ-021 Lock qualify: rst_n_i released and lock_i=1 held -> first sof_o=1 exactly 5 cycles after the first lock_i=1 sample (4 qualification cycles plus 1 output register), with x_o=0, y_o=0, de_o=1.
REQ-022 Line timing: in RUN -> de_o=1 for 4 cycles with x_o=0,1,2,3, then hs_o high 1 cycle, low 2 cycles, high 1 cycle; period 8 cycles.
REQ-023 Frame timing: in RUN -> de_o lines at y_o=0..2, vs_o low for exactly 8 cycles starting at line 4; next sof_o 48 cycles after the previous one.
REQ-024 Lock glitch: lock_i=0 for 1 cycle mid-line -> next output cycle idle (hs_o=vs_o=1, de_o=run_o=0); next sof_o only after 4 new consecutive lock_i=1 samples. Also lock_i=1,1,1,0,1,1,1,1 in WAIT_LOCK -> RUN is entered only after the last 4 high samples.
REQ-025 Reset mid-frame: rst_n_i=0 for 1 cycle during active video with lock_i=1 -> outputs idle on the next edge; sof_o recurs 5 cycles after release.
